encoder_reg: RTL and testbench
==============================

Name: encoder_reg

Overview:
- Registered priority encoder with valid/ready handshake; the inverse of the 2-to-4 `decoder`.
- Compresses a one-hot (nominally) request vector back into a binary index.
- Flags zero-hot and multi-hot inputs, and keeps a saturating count of multi-hot events.
- Sits downstream of decoder-driven select logic to recover the index and to check one-hot integrity.

Parameters:
- OUT_W, 2, width of the encoded index; input width IN_W = 2**OUT_W (default 4).
- CNT_W, 8, width of the multi-hot error counter.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  reset; asynchronous, active-high.
- in  input  IN_W  request vector to encode.
- en  input  1  encoder enable; when 0, no capture occurs.
- in_valid  input  1  `in` is valid this cycle.
- in_ready  output  1  block can accept `in` this cycle.
- out  output  OUT_W  encoded index.
- out_valid  output  1  `out`, `out_zero` and `out_multi` are valid.
- out_ready  input  1  downstream accepts the output this cycle.
- out_zero  output  1  captured `in` was all zeros.
- out_multi  output  1  captured `in` had more than one bit set.
- err_cnt  output  CNT_W  saturating count of accepted multi-hot inputs.
- cnt_clr  input  1  synchronous clear of `err_cnt`.

Behaviour:
- Reset (async assert, sync-released by the source): out=0, out_valid=0, out_zero=0, out_multi=0, err_cnt=0. State goes to EMPTY.
- Single output register, two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- in_ready = !out_valid || out_ready (combinational), so full throughput is possible.
- accept = en && in_valid && in_ready. On accept, at the next rising edge the register loads:
  - out = index of the highest set bit of `in` (MSB priority).
  - out_zero = (in == 0); out is 0 in that case.
  - out_multi = (popcount(in) > 1).
  - Latency: 1 cycle from accept to out_valid.
- Transitions:
  - EMPTY, accept -> FULL.
  - FULL, out_ready && !accept -> EMPTY.
  - FULL, out_ready && accept -> FULL with the new data (back-to-back, no bubble).
  - FULL, !out_ready -> FULL; out, out_zero and out_multi held stable.
- en=0: accept is suppressed regardless of in_valid. in_ready still reflects register occupancy. A held FULL entry still drains normally.
- in_valid may drop without acceptance; no state change.
- err_cnt:
  - Increments by 1 on every accept with popcount(in) > 1.
  - Saturates at 2**CNT_W-1; no wrap.
  - cnt_clr has priority over the increment: if both occur in the same cycle, the result is 0.
- Reset mid-transfer: any pending output is discarded, out_valid drops immediately, and err_cnt clears.
- Purely synchronous datapath otherwise. No combinational path from `in` to `out`.

Optional Feature:
- Macro: ENCODER_REG_LSB_PRIO_EN.
- Defined: priority is LSB-first, i.e. out = index of the lowest set bit.
- Undefined: MSB-first as above.
- out_zero, out_multi and err_cnt are unaffected either way.

Test Plan:
- Reset: assert rst with in_valid=1, en=1, in=4'b0100 -> during reset out_valid=0, out=0, err_cnt=0. After release, the first accept gives out=2, out_valid=1 one cycle later.
- One-hot sweep, en=1, out_ready=1, in=0001/0010/0100/1000 on consecutive cycles -> out=0,1,2,3 on consecutive cycles. out_valid stays 1; out_zero=0, out_multi=0.
- Backpressure: in=1000 accepted, then out_ready=0 for 3 cycles with in=0001 presented.
  - in_ready=0 and out=3 held for those 3 cycles.
  - With out_ready=1, out=0 appears the next cycle.
- Zero and multi-hot:
  - in=0000 -> out=0, out_zero=1.
  - in=0110 -> out=2 (MSB prio; out=1 with ENCODER_REG_LSB_PRIO_EN), out_multi=1, err_cnt increments 0->1.
- Enable gating: en=0, in_valid=1, in=0100 for 4 cycles -> out_valid stays 0, no capture. Raising en yields out=2 one cycle later.
- Counter saturation and clear:
  - Apply 260 multi-hot accepts (in=1111) -> err_cnt=255 and holds.
  - cnt_clr together with a multi-hot accept -> err_cnt=0.

Source files
------------

// File: rtl/encoder_reg.sv
// encoder_reg -- registered priority encoder with a valid/ready handshake.
//
// Compresses a (nominally one-hot) request vector into a binary index and
// flags zero-hot and multi-hot inputs. A saturating counter tracks how many
// multi-hot vectors were accepted. There is one output register, so the
// block holds at most one result. in_ready is combinational so that a full
// register can be drained and refilled in the same cycle.
//
// Configuration macro:
//   ENCODER_REG_LSB_PRIO_EN  defined   -> out = index of lowest set bit
//                            undefined -> out = index of highest set bit
//
// Parameters:
//   OUT_W  width of the encoded index; input width is 2**OUT_W
//   CNT_W  width of the multi-hot error counter
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in         request vector to encode
//   en         encoder enable; 0 suppresses capture
//   in_valid   in is valid this cycle
//   in_ready   block can accept in this cycle
//   out        encoded index
//   out_valid  out / out_zero / out_multi are valid
//   out_ready  downstream accepts the output this cycle
//   out_zero   captured vector was all zeros
//   out_multi  captured vector had more than one bit set
//   err_cnt    saturating count of accepted multi-hot vectors
//   cnt_clr    synchronous clear of err_cnt (wins over an increment)

module encoder_reg #(
  parameter int OUT_W = 2,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2**OUT_W-1:0]   in,
  input  logic                  en,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [OUT_W-1:0]      out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_zero,
  output logic                  out_multi,
  output logic [CNT_W-1:0]      err_cnt,
  input  logic                  cnt_clr
);

  localparam int IN_W = 2**OUT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t             state_r;
  logic [OUT_W-1:0]   out_r;
  logic               out_valid_r;
  logic               out_zero_r;
  logic               out_multi_r;
  logic [CNT_W-1:0]   err_cnt_r;

  logic               accept_s;
  logic [OUT_W-1:0]   index_s;
  logic               zero_s;
  logic               multi_s;

  // Priority encode: a later match in the scan overrides an earlier one, so
  // the scan direction selects which end of the vector wins.
  function automatic logic [OUT_W-1:0] prio_index(input logic [IN_W-1:0] vec);
    logic [OUT_W-1:0] idx;
    idx = {OUT_W{1'b0}};
`ifdef ENCODER_REG_LSB_PRIO_EN
    for (int i = IN_W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = OUT_W'(i);
      end else begin
        idx = idx;
      end
    end
`else
    for (int i = 0; i < IN_W; i++) begin
      if (vec[i]) begin
        idx = OUT_W'(i);
      end else begin
        idx = idx;
      end
    end
`endif
    return idx;
  endfunction

  // More than one bit set: clearing the lowest set bit leaves something.
  function automatic logic is_multi(input logic [IN_W-1:0] vec);
    logic [IN_W-1:0] rest;
    rest = vec & (vec - {{(IN_W-1){1'b0}}, 1'b1});
    return (rest != {IN_W{1'b0}});
  endfunction

  // Handshake and encode of the incoming vector.
  always_comb begin
    in_ready = !out_valid_r || out_ready;
    accept_s = en && in_valid && in_ready;
    index_s  = prio_index(in);
    zero_s   = (in == {IN_W{1'b0}});
    multi_s  = is_multi(in);
  end

  // Output register state machine; holds data stable while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= EMPTY;
      out_r       <= {OUT_W{1'b0}};
      out_valid_r <= 1'b0;
      out_zero_r  <= 1'b0;
      out_multi_r <= 1'b0;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            state_r     <= FULL;
            out_valid_r <= 1'b1;
            out_r       <= index_s;
            out_zero_r  <= zero_s;
            out_multi_r <= multi_s;
          end else begin
            state_r     <= EMPTY;
            out_valid_r <= 1'b0;
          end
        end
        FULL: begin
          if (accept_s) begin
            // accept implies out_ready here: drain and refill, no bubble
            state_r     <= FULL;
            out_valid_r <= 1'b1;
            out_r       <= index_s;
            out_zero_r  <= zero_s;
            out_multi_r <= multi_s;
          end else if (out_ready) begin
            state_r     <= EMPTY;
            out_valid_r <= 1'b0;
          end else begin
            state_r     <= FULL;
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= EMPTY;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Saturating multi-hot counter; clear wins over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_clr) begin
      err_cnt_r <= {CNT_W{1'b0}};
    end else if (accept_s && multi_s && (err_cnt_r != CNT_MAX)) begin
      err_cnt_r <= err_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign out       = out_r;
  assign out_valid = out_valid_r;
  assign out_zero  = out_zero_r;
  assign out_multi = out_multi_r;
  assign err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_encoder_reg.sv
// Self-checking bench for encoder_reg: directed test-plan steps followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_encoder_reg;

  localparam int OUT_W = 2;
  localparam int CNT_W = 8;
  localparam int IN_W  = 4;
  localparam int CNT_MAX = 255;

  logic             clk = 1'b0;
  logic             rst;
  logic [IN_W-1:0]  in;
  logic             en;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] out;
  logic             out_valid;
  logic             out_ready;
  logic             out_zero;
  logic             out_multi;
  logic [CNT_W-1:0] err_cnt;
  logic             cnt_clr;

  encoder_reg #(.OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in(in), .en(en), .in_valid(in_valid),
    .in_ready(in_ready), .out(out), .out_valid(out_valid),
    .out_ready(out_ready), .out_zero(out_zero), .out_multi(out_multi),
    .err_cnt(err_cnt), .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int zero;
    int multi;
  } res_t;

  res_t q[$];
  int   cnt_m = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  // Expected index from plain arithmetic on the vector value.
  function automatic int exp_index(input int v);
    if (v == 0) return 0;
`ifdef ENCODER_REG_LSB_PRIO_EN
    return $clog2(v & -v);
`else
    return $clog2(v + 1) - 1;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("out_valid", {31'd0, out_valid}, (q.size() != 0) ? 32'd1 : 32'd0);
    if (q.size() != 0) begin
      check("out", {30'd0, out}, q[0].idx);
      check("out_zero", {31'd0, out_zero}, q[0].zero);
      check("out_multi", {31'd0, out_multi}, q[0].multi);
    end else if (rst) begin
      check("rst_out", {30'd0, out}, 32'd0);
      check("rst_out_zero", {31'd0, out_zero}, 32'd0);
      check("rst_out_multi", {31'd0, out_multi}, 32'd0);
    end
    check("err_cnt", {24'd0, err_cnt}, cnt_m);
  endtask

  // One clock cycle: check in_ready, advance the model at the edge, check outputs.
  task automatic step();
    bit   acc;
    res_t r;
    if (rst) begin
      q.delete();
      cnt_m = 0;
    end
    #1;
    check("in_ready", {31'd0, in_ready}, (q.size() == 0 || out_ready) ? 32'd1 : 32'd0);
    @(posedge clk);
    if (!rst) begin
      acc = en && in_valid && (q.size() == 0 || out_ready);
      if (q.size() != 0 && out_ready) void'(q.pop_front());
      if (acc) begin
        r.idx   = exp_index(int'(in));
        r.zero  = (in == 4'd0) ? 1 : 0;
        r.multi = ($countones(in) > 1) ? 1 : 0;
        q.push_back(r);
      end
      if (cnt_clr) cnt_m = 0;
      else if (acc && $countones(in) > 1 && cnt_m < CNT_MAX) cnt_m++;
    end
    #1;
    check_outputs();
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; in_valid = 1'b1; in = 4'b0100;
    out_ready = 1'b1; cnt_clr = 1'b0;

    // Reset held with a valid request present
    step();
    step();
    rst = 1'b0;
    step();
    check("reset_first_out", {30'd0, out}, 32'd2);

    // One-hot sweep, full throughput
    for (int i = 0; i < 4; i++) begin
      in = 4'(1 << i);
      step();
      check("sweep_out", {30'd0, out}, i);
    end

    // Backpressure
    in = 4'b1000;
    step();
    out_ready = 1'b0;
    in = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold", {30'd0, out}, 32'd3);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    step();
    check("bp_release", {30'd0, out}, 32'd0);

    // Zero and multi-hot
    in = 4'b0000;
    step();
    check("zero_flag", {31'd0, out_zero}, 32'd1);
    in = 4'b0110;
    step();
    check("multi_flag", {31'd0, out_multi}, 32'd1);
    check("multi_cnt", {24'd0, err_cnt}, 32'd1);

    // Enable gating
    en = 1'b0; in = 4'b0100;
    for (int i = 0; i < 4; i++) step();
    check("en_gated", {31'd0, out_valid}, 32'd0);
    en = 1'b1;
    step();
    check("en_raise", {30'd0, out}, 32'd2);

    // Counter saturation and clear
    in = 4'b1111;
    for (int i = 0; i < 260; i++) step();
    check("cnt_sat", {24'd0, err_cnt}, 32'd255);
    cnt_clr = 1'b1;
    step();
    check("cnt_clr", {24'd0, err_cnt}, 32'd0);
    cnt_clr = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      in        = 4'($urandom_range(0, 15));
      en        = ($urandom % 4) != 0;
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      cnt_clr   = ($urandom % 32) == 0;
      step();
    end

    // Reset in the middle of a pending transfer
    en = 1'b1; in_valid = 1'b1; in = 4'b1111; out_ready = 1'b0; cnt_clr = 1'b0;
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_cnt", {24'd0, err_cnt}, 32'd0);
    step();
    rst = 1'b0;
    out_ready = 1'b1; in = 4'b0010;
    step();
    check("post_rst_out", {30'd0, out}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
